// File: rtl/cond_logic_pkg.sv
// Shared ARM condition-code encodings, NZCV flag bit positions and flag-write select bits.
// Imported by the condition checker, the flag/counter block and the control decoder.
package cond_logic_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N   = 3;
  localparam int FLAG_Z   = 2;
  localparam int FLAG_C   = 1;
  localparam int FLAG_V   = 0;
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_logic_if.sv
// Decoder/ALU-to-condition-logic bundle: instruction qualifiers and requests in,
// gated write enables, registered flags and the debug skip counter out.
interface cond_logic_if #(parameter int CNT_W = 16);
  logic             en;
  logic [3:0]       cond;
  logic [3:0]       alu_flags;
  logic [1:0]       flag_w;
  logic             pcs_in;
  logic             regw_in;
  logic             memw_in;
  logic             nowrite_in;
  logic             pcsrc;
  logic             regwrite;
  logic             memwrite;
  logic             cond_ex;
  logic [3:0]       flags_q;
  logic [CNT_W-1:0] skip_cnt;

  modport master (
    output en, cond, alu_flags, flag_w, pcs_in, regw_in, memw_in, nowrite_in,
    input  pcsrc, regwrite, memwrite, cond_ex, flags_q, skip_cnt
  );

  modport slave (
    input  en, cond, alu_flags, flag_w, pcs_in, regw_in, memw_in, nowrite_in,
    output pcsrc, regwrite, memwrite, cond_ex, flags_q, skip_cnt
  );
endinterface

// File: rtl/cond_logic_cond_check.sv
// Pure combinational ARM condition evaluator: 4-bit condition field against {N,Z,C,V}.
module cond_check
  import cond_logic_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n_s, z_s, c_s, v_s;

  assign n_s = flags[FLAG_N];
  assign z_s = flags[FLAG_Z];
  assign c_s = flags[FLAG_C];
  assign v_s = flags[FLAG_V];

  // condition decode table
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z_s;
      COND_NE: pass = ~z_s;
      COND_CS: pass = c_s;
      COND_CC: pass = ~c_s;
      COND_MI: pass = n_s;
      COND_PL: pass = ~n_s;
      COND_VS: pass = v_s;
      COND_VC: pass = ~v_s;
      COND_HI: pass = c_s & ~z_s;
      COND_LS: pass = ~c_s | z_s;
      COND_GE: pass = (n_s == v_s);
      COND_LT: pass = (n_s != v_s);
      COND_GT: pass = ~z_s & (n_s == v_s);
      COND_LE: pass = z_s | (n_s != v_s);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: holds the NZCV register, gates decoder write requests
// on the condition result, and counts skipped valid instructions (saturating).
module cond_logic
  import cond_logic_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  cond_logic_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       flags_r;
  logic [CNT_W-1:0] skip_r;
  logic             pass_s;
  logic             cond_ex_s;

  // Decode reads the registered flags so an instruction sees its predecessors' result.
  cond_check u_cond_check (
    .cond  (bus.cond),
    .flags (flags_r),
    .pass  (pass_s)
  );

  assign cond_ex_s    = bus.en & pass_s;
  assign bus.cond_ex  = cond_ex_s;
  assign bus.pcsrc    = bus.pcs_in  & cond_ex_s;
  assign bus.regwrite = bus.regw_in & cond_ex_s & ~bus.nowrite_in;
  assign bus.memwrite = bus.memw_in & cond_ex_s;
  assign bus.flags_q  = flags_r;
  assign bus.skip_cnt = skip_r;

  // flag register: each half written independently, only by a passing instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_r <= 4'b0000;
    end else if (cond_ex_s) begin
      if (bus.flag_w[FLAGW_NZ]) begin
        flags_r[FLAG_N] <= bus.alu_flags[FLAG_N];
        flags_r[FLAG_Z] <= bus.alu_flags[FLAG_Z];
      end
      if (bus.flag_w[FLAGW_CV]) begin
        flags_r[FLAG_C] <= bus.alu_flags[FLAG_C];
        flags_r[FLAG_V] <= bus.alu_flags[FLAG_V];
      end
    end
  end

  // saturating count of valid instructions whose condition failed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skip_r <= {CNT_W{1'b0}};
    end else if (bus.en && !cond_ex_s && (skip_r != CNT_MAX)) begin
      skip_r <= skip_r + CNT_ONE;
    end
  end

endmodule
